// File: rtl/tensor_output_adder_seq.sv
// tensor_output_adder_seq
// Sequencer for the tensor unit's final-stage output adder. It walks a ROWS x COLS
// output matrix one element at a time. For each element it reads the partial-sum
// buffer, clears and fires the one-shot adder, and waits ADD_LAT cycles. It then
// captures the 16-bit signed sum and presents it with its element index on a
// valid/ready port.
//
// Optional feature: define TOA_SEQ_STALL_CNT_EN to add the 16-bit stall_cnt output.
// It counts back-pressure cycles within the current pass.

module tensor_output_adder_seq #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ADDR_W  = 4,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] elem_addr,
  output logic              elem_rd,
  output logic              add_clr,
  output logic              add_start,
  input  logic [15:0]       add_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [ADDR_W-1:0] out_addr
`ifdef TOA_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // The wait counter only needs to hold ADD_LAT-1; keep at least one bit so that
  // ADD_LAT == 1 still gives a legal vector.
  localparam int LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(ADD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(ROWS * COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CLEAR,
    S_ADD,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [LAT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [15:0]       outData_q, outData_d;
  logic [ADDR_W-1:0] outAddr_q, outAddr_d;

  // State, element index, latency counter and captured result; reset aborts any pass in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      waitCnt_q <= '0;
      outData_q <= '0;
      outAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      waitCnt_q <= waitCnt_d;
      outData_q <= outData_d;
      outAddr_q <= outAddr_d;
    end
  end

  // Next-state logic plus state-decoded strobes; every strobe lives in exactly one state per element
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    waitCnt_d = waitCnt_q;
    outData_d = outData_q;
    outAddr_d = outAddr_q;
    busy      = 1'b0;
    done      = 1'b0;
    elem_addr = '0;
    elem_rd   = 1'b0;
    add_clr   = 1'b0;
    add_start = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_FETCH;
          index_d = '0;
        end
      end

      S_FETCH: begin
        busy      = 1'b1;
        elem_addr = index_q;
        elem_rd   = 1'b1;
        state_d   = S_CLEAR;
      end

      S_CLEAR: begin
        busy      = 1'b1;
        elem_addr = index_q;
        add_clr   = 1'b1;
        state_d   = S_ADD;
      end

      S_ADD: begin
        busy      = 1'b1;
        elem_addr = index_q;
        add_start = 1'b1;
        waitCnt_d = LAT_LOAD;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        busy      = 1'b1;
        elem_addr = index_q;
        if (waitCnt_q == '0) begin
          outData_d = add_result;
          outAddr_d = index_q;
          state_d   = S_EMIT;
        end else begin
          waitCnt_d = waitCnt_q - 1'b1;
        end
      end

      S_EMIT: begin
        busy      = 1'b1;
        elem_addr = index_q;
        out_valid = 1'b1;
        if (out_ready) begin
          if (index_q == LAST_ELEM) begin
            state_d = S_DONE;
          end else begin
            index_d = index_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        index_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_data = outData_q;
  assign out_addr = outAddr_q;

`ifdef TOA_SEQ_STALL_CNT_EN
  logic [15:0] stallCnt_q, stallCnt_d;

  // Back-pressure counter: restarts with each accepted go, saturates, and survives DONE
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (state_q == S_IDLE && go) begin
      stallCnt_d = '0;
    end else if (state_q == S_EMIT && !out_ready && stallCnt_q != 16'hFFFF) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
`endif

endmodule
